reg_writeback_unit: RTL

- Write-side companion of the register-file decoder: produces the RegWrite / write-address / data_to_reg triple that the register file consumes.
- Merges two result sources into one registered write port:
  - single-cycle ALU results, buffered in a small FIFO;
  - one outstanding memory load, tracked by an FSM and sign/zero-extended by funct3.
- Exports load-pending status so the issue logic can stall on RAW hazards.

---
 rtl/reg_writeback_unit_if.sv | 45 ++++
 rtl/reg_writeback_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit_if.sv
// Bundle of the writeback unit's ALU, load-request, memory-response and register-write signals.
// The master side drives results and loads into the unit; the slave side is the unit itself.
interface reg_writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;

  logic            ld_req_valid;
  logic            ld_req_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;

  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            ld_pending;
  logic [4:0]      ld_pending_rd;
  logic            ld_err;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_req_valid, ld_rd, ld_funct3, ld_addr_lo,
    output mem_rvalid, mem_rdata,
    input  alu_ready, ld_req_ready,
    input  wb_we, wb_rd, wb_data,
    input  ld_pending, ld_pending_rd, ld_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_req_valid, ld_rd, ld_funct3, ld_addr_lo,
    input  mem_rvalid, mem_rdata,
    output alu_ready, ld_req_ready,
    output wb_we, wb_rd, wb_data,
    output ld_pending, ld_pending_rd, ld_err
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Register-file write port: merges buffered ALU results with one outstanding, extended memory load.
// Load responses win arbitration; the ALU FIFO drains whenever no load is completing.
module reg_writeback_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input logic                clk,
  input logic                reset,
  reg_writeback_unit_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state;
  logic [4:0] lat_rd;
  logic [2:0] lat_funct3;
  logic [1:0] lat_off;

  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic            wb_we_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            ld_err_q;

  logic            full;
  logic            empty;
  logic            waw_block;
  logic            push;
  logic            pop;
  logic            ld_commit;
  logic            ld_bad;
  logic [XLEN-1:0] ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  // An ALU write to the rd of an in-flight load must wait, or the older load would overwrite it.
  assign waw_block = bus.ld_pending && (bus.alu_rd == bus.ld_pending_rd) && (bus.alu_rd != '0);

  assign bus.alu_ready     = !full && !waw_block;
  assign bus.ld_req_ready  = (state == S_IDLE);
  assign bus.ld_pending    = (state == S_WAIT);
  assign bus.ld_pending_rd = (state == S_WAIT) ? lat_rd : '0;

  assign push      = bus.alu_valid && bus.alu_ready;
  assign ld_commit = (state == S_WAIT) && bus.mem_rvalid;
  assign pop       = !ld_commit && !empty;

  assign ld_byte = bus.mem_rdata[{lat_off, 3'b000} +: 8];
  assign ld_half = lat_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ld_data = '0;
    ld_bad  = 1'b0;
    unique case (lat_funct3)
      3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        if (lat_off[0]) ld_bad  = 1'b1;
        else            ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      end
      3'b101: begin
        if (lat_off[0]) ld_bad  = 1'b1;
        else            ld_data = {{(XLEN-16){1'b0}}, ld_half};
      end
      3'b010: begin
        if (lat_off != 2'b00) ld_bad  = 1'b1;
        else                  ld_data = bus.mem_rdata;
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_rd     <= '0;
      lat_funct3 <= '0;
      lat_off    <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.ld_req_valid) begin
          state      <= S_WAIT;
          lat_rd     <= bus.ld_rd;
          lat_funct3 <= bus.ld_funct3;
          lat_off    <= bus.ld_addr_lo;
        end
        S_WAIT: if (bus.mem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage is not reset; occupancy is tracked by the reset pointers and count,
  // so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.alu_rd;
      fifo_data[wr_ptr] <= bus.alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // x0 commits are consumed without touching the write port; wb_rd/wb_data keep the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      wb_we_q  <= 1'b0;
      ld_err_q <= 1'b0;
      if (ld_commit) begin
        ld_err_q <= ld_bad;
        if (lat_rd != '0) begin
          wb_we_q   <= 1'b1;
          wb_rd_q   <= lat_rd;
          wb_data_q <= ld_data;
        end
      end else if (pop) begin
        if (fifo_rd[rd_ptr] != '0) begin
          wb_we_q   <= 1'b1;
          wb_rd_q   <= fifo_rd[rd_ptr];
          wb_data_q <= fifo_data[rd_ptr];
        end
      end
    end
  end

  assign bus.wb_we   = wb_we_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;
  assign bus.ld_err  = ld_err_q;
endmodule
